// File: rtl/ahb_lsu_pkg.sv
// ahb_lsu_pkg
// Shared encodings for the load/store unit: AHB transfer types, AHB size
// codes, the decoder's request size encoding and the LSU state machine.
package ahb_lsu_pkg;

    // AHB-Lite transfer types (only IDLE and NONSEQ are ever issued)
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // AHB HSIZE codes
    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    // Decoder request size encoding
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10,
        ST_ERR  = 2'b11
    } lsu_state_t;

    // Map a legal request size onto the AHB size code.
    function automatic logic [2:0] to_hsize(input logic [1:0] size);
        logic [2:0] hs;
        case (size)
            SIZE_BYTE: hs = HSIZE_BYTE;
            SIZE_HALF: hs = HSIZE_HALF;
            default:   hs = HSIZE_WORD;
        endcase
        return hs;
    endfunction

endpackage

// File: rtl/ahb_lsu_load_align.sv
// lsu_load_align
// Combinational load data alignment: picks the addressed byte or halfword
// lane and zero/sign-extends it, or rotates a word right by 8*a so that an
// unaligned word load returns the classic rotated value.
// Ports:
//   i_rdata  : raw AHB read data
//   i_a      : registered address bits [1:0]
//   i_size   : request size (byte/half/word)
//   i_signed : sign-extend byte/halfword
//   o_data   : aligned, extended load data
module lsu_load_align
    import ahb_lsu_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_a,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_rot;

    always_comb begin
        w_byte = i_rdata[7:0];
        w_rot  = i_rdata;
        case (i_a)
            2'd0: begin w_byte = i_rdata[7:0];   w_rot = i_rdata;                          end
            2'd1: begin w_byte = i_rdata[15:8];  w_rot = {i_rdata[7:0],  i_rdata[31:8]};  end
            2'd2: begin w_byte = i_rdata[23:16]; w_rot = {i_rdata[15:0], i_rdata[31:16]}; end
            default: begin w_byte = i_rdata[31:24]; w_rot = {i_rdata[23:0], i_rdata[31:24]}; end
        endcase
    end

    // Halfword lane is chosen by a[1] only; a[0] is ignored (address was aligned on the bus).
    assign w_half = i_a[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        case (i_size)
            SIZE_BYTE: o_data = {{24{i_signed & w_byte[7]}}, w_byte};
            SIZE_HALF: o_data = {{16{i_signed & w_half[15]}}, w_half};
            default:   o_data = w_rot;
        endcase
    end

endmodule

// File: rtl/ahb_lsu.sv
// ahb_lsu
// Load/store unit: converts one decoded memory request at a time into a
// single AHB-Lite transfer, returns aligned load data to writeback tagged
// with the destination id, and raises a data abort on bus error or an
// illegal request size.
// Ports:
//   clk, rst_n                : clock, asynchronous active-low reset
//   req_valid/req_ready       : request handshake (ready only when idle)
//   req_wr/rd/size/signed     : decoded request type
//   req_addr/wdata/id         : address, store data, load destination id
//   wb_valid/wb_id/wb_data    : load completion pulse and held data
//   abort                     : one-cycle data abort pulse
//   HADDR..HRESP              : AHB-Lite master interface
module ahb_lsu
    import ahb_lsu_pkg::*;
#(
    parameter int ID_W   = 5,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic              req_rd,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [ID_W-1:0]   req_id,
    output logic              wb_valid,
    output logic [ID_W-1:0]   wb_id,
    output logic [31:0]       wb_data,
    output logic              abort,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [31:0]       HWDATA,
    input  logic [31:0]       HRDATA,
    input  logic              HREADY,
    input  logic              HRESP
);

    lsu_state_t        r_state;
    logic              r_wr;
    logic [1:0]        r_size;
    logic              r_signed;
    logic [1:0]        r_a;
    logic [ID_W-1:0]   r_id;
    logic [31:0]       r_wdata;
    logic [ADDR_W-1:0] r_haddr;
    logic [31:0]       r_hwdata;
    logic              r_wb_valid;
    logic [ID_W-1:0]   r_wb_id;
    logic [31:0]       r_wb_data;
    logic              r_abort;

    logic [ADDR_W-1:0] w_haddr_aligned;
    logic [31:0]       w_lane_wdata;
    logic [31:0]       w_load_data;

    // The bus sees a size-aligned address; the low bits are kept in r_a for load extraction.
    always_comb begin
        w_haddr_aligned = req_addr;
        case (req_size)
            SIZE_HALF: w_haddr_aligned = {req_addr[ADDR_W-1:1], 1'b0};
            SIZE_WORD: w_haddr_aligned = {req_addr[ADDR_W-1:2], 2'b00};
            default:   w_haddr_aligned = req_addr;
        endcase
    end

    // Replicate narrow store data on every lane so the slave can pick any.
    always_comb begin
        w_lane_wdata = r_wdata;
        case (r_size)
            SIZE_BYTE: w_lane_wdata = {4{r_wdata[7:0]}};
            SIZE_HALF: w_lane_wdata = {2{r_wdata[15:0]}};
            default:   w_lane_wdata = r_wdata;
        endcase
    end

    lsu_load_align u_align (
        .i_rdata  (HRDATA),
        .i_a      (r_a),
        .i_size   (r_size),
        .i_signed (r_signed),
        .o_data   (w_load_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_wr       <= 1'b0;
            r_size     <= 2'b00;
            r_signed   <= 1'b0;
            r_a        <= 2'b00;
            r_id       <= '0;
            r_wdata    <= '0;
            r_haddr    <= '0;
            r_hwdata   <= '0;
            r_wb_valid <= 1'b0;
            r_wb_id    <= '0;
            r_wb_data  <= '0;
            r_abort    <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_abort    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // A request with neither wr nor rd is consumed as a no-op.
                    if (req_valid && (req_wr || req_rd)) begin
                        if (req_size == SIZE_ILL) begin
                            r_abort <= 1'b1;
                        end else begin
                            r_state  <= ST_ADDR;
                            r_wr     <= req_wr;
                            r_size   <= req_size;
                            r_signed <= req_signed;
                            r_a      <= req_addr[1:0];
                            r_id     <= req_id;
                            r_wdata  <= req_wdata;
                            r_haddr  <= w_haddr_aligned;
                        end
                    end
                end
                ST_ADDR: begin
                    if (HREADY) begin
                        r_state  <= ST_DATA;
                        r_hwdata <= w_lane_wdata;
                    end
                end
                ST_DATA: begin
                    if (HREADY) begin
                        r_state <= ST_IDLE;
                        // ERROR seen only on its final cycle is still an error.
                        if (HRESP) begin
                            r_abort <= 1'b1;
                        end else if (!r_wr) begin
                            r_wb_valid <= 1'b1;
                            r_wb_id    <= r_id;
                            r_wb_data  <= w_load_data;
                        end
                    end else if (HRESP) begin
                        r_state <= ST_ERR;
                    end
                end
                ST_ERR: begin
                    if (HREADY) begin
                        r_state <= ST_IDLE;
                        r_abort <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign HTRANS    = (r_state == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign HADDR     = r_haddr;
    assign HWRITE    = r_wr;
    assign HSIZE     = to_hsize(r_size);
    assign HWDATA    = r_hwdata;
    assign wb_valid  = r_wb_valid;
    assign wb_id     = r_wb_id;
    assign wb_data   = r_wb_data;
    assign abort     = r_abort;

endmodule
